// File: rtl/mdv_unit.sv
// Multiply/divide unit for the EX stage: owns HI/LO, runs timed mult/div
// operations and reports busy/stall to the hazard unit.
module mdv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDVop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDV_ans
);

  typedef enum logic [2:0] {
    MDV_mult, MDV_multu, MDV_div, MDV_divu,
    MDV_mthi, MDV_mtlo, MDV_mfhi, MDV_mflo
  } mdvOp_t;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_t        r_state, w_stateNext;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi, r_lo;
  logic [31:0]   r_resHi, r_resLo;
  logic          r_resValid;

  mdvOp_t        w_op;
  logic          w_isMul, w_isDiv, w_accept, w_last;
  logic [63:0]   w_mulA, w_mulB, w_prod;
  logic [31:0]   w_absA, w_absB, w_numer, w_denom, w_denomSafe;
  logic [31:0]   w_quo, w_rem, w_resHi, w_resLo;

  assign w_op     = mdvOp_t'(MDVop);
  assign w_isMul  = (w_op == MDV_mult) || (w_op == MDV_multu);
  assign w_isDiv  = (w_op == MDV_div)  || (w_op == MDV_divu);
  assign w_accept = start && !Req && (w_isMul || w_isDiv) && (r_state == IDLE);
  assign w_last   = (r_cnt == CW'(1));

  // Signed division is done on magnitudes, so 0x80000000 / -1 wraps cleanly
  // and the divide-by-zero case never feeds a zero divisor to the datapath.
  always_comb begin
    w_mulA      = {{32{A[31] & (w_op == MDV_mult)}}, A};
    w_mulB      = {{32{B[31] & (w_op == MDV_mult)}}, B};
    w_prod      = w_mulA * w_mulB;
    w_absA      = A[31] ? (32'd0 - A) : A;
    w_absB      = B[31] ? (32'd0 - B) : B;
    w_numer     = (w_op == MDV_div) ? w_absA : A;
    w_denom     = (w_op == MDV_div) ? w_absB : B;
    w_denomSafe = (w_denom == 32'd0) ? 32'd1 : w_denom;
    w_quo       = w_numer / w_denomSafe;
    w_rem       = w_numer % w_denomSafe;
    w_resHi     = w_prod[63:32];
    w_resLo     = w_prod[31:0];
    if (w_op == MDV_div) begin
      w_resLo = (A[31] ^ B[31]) ? (32'd0 - w_quo) : w_quo;
      w_resHi = A[31] ? (32'd0 - w_rem) : w_rem;
    end else if (w_op == MDV_divu) begin
      w_resLo = w_quo;
      w_resHi = w_rem;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (w_accept) w_stateNext = RUN;
      RUN:  if (w_last)   w_stateNext = IDLE;
      default:            w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_resHi    <= '0;
      r_resLo    <= '0;
      r_resValid <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == IDLE) begin
        if (w_accept) begin
          r_cnt      <= w_isMul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          r_resHi    <= w_resHi;
          r_resLo    <= w_resLo;
          r_resValid <= !(w_isDiv && (B == 32'd0));
        end else if (!Req && (w_op == MDV_mthi)) begin
          r_hi <= A;
        end else if (!Req && (w_op == MDV_mtlo)) begin
          r_lo <= A;
        end
      end else begin
        r_cnt <= r_cnt - CW'(1);
        if (w_last && r_resValid) begin
          r_hi <= r_resHi;
          r_lo <= r_resLo;
        end
      end
    end
  end

  assign busy    = (r_state == RUN);
  assign stall   = start | busy;
  assign HI      = r_hi;
  assign LO      = r_lo;
  assign MDV_ans = (w_op == MDV_mfhi) ? r_hi :
                   (w_op == MDV_mflo) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdv_unit.sv
// Self-checking bench for mdv_unit: a scoreboard queue holds expected HI/LO
// pairs pushed at command issue and popped when busy drops.
module tb_mdv_unit;

  localparam logic [2:0] OP_MULT  = 3'd0, OP_MULTU = 3'd1, OP_DIV  = 3'd2, OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4, OP_MTLO  = 3'd5, OP_MFHI = 3'd6, OP_MFLO = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  MDVop = OP_MFLO;
  logic [31:0] A = '0, B = '0;
  logic        Req = 1'b0;
  logic        busy, stall;
  logic [31:0] HI, LO, MDV_ans;

  int          errCount = 0;
  int          checkCount = 0;
  logic [31:0] mHi = '0, mLo = '0;
  logic [63:0] scoreboard[$];

  mdv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .MDVop(MDVop), .A(A), .B(B),
    .Req(Req), .busy(busy), .stall(stall), .HI(HI), .LO(LO), .MDV_ans(MDV_ans)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Reference arithmetic on 64-bit integers, independent of the RTL datapath.
  function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [63:0] cur);
    longint sa, sb, ua, ub, q, r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      OP_MULT:  return sa * sb;
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 32'd0) return cur;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 32'd0) return cur;
        q = ua / ub;
        r = ua % ub;
        return {r[31:0], q[31:0]};
      end
      default: return cur;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic rq);
    start = st;
    MDVop = op;
    A     = a;
    B     = b;
    Req   = rq;
    step();
    start = 1'b0;
    Req   = 1'b0;
    MDVop = OP_MFLO;
  endtask

  task automatic issueOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    scoreboard.push_back(refModel(op, a, b, {mHi, mLo}));
    applyStimulus(1'b1, op, a, b, 1'b0);
  endtask

  // Counts busy cycles (bounded), then pops and compares the committed result.
  task automatic waitDone(input string tag, input int preCount, input int expLen);
    int          cycles;
    logic [63:0] exp;
    cycles = preCount;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      step();
    end
    checkOutput({tag, "_busyLen"}, 64'(cycles), 64'(expLen));
    if (scoreboard.size() == 0) begin
      checkOutput({tag, "_sbEmpty"}, 64'd0, 64'd1);
    end else begin
      exp = scoreboard.pop_front();
      checkOutput({tag, "_HI"}, {32'd0, HI}, {32'd0, exp[63:32]});
      checkOutput({tag, "_LO"}, {32'd0, LO}, {32'd0, exp[31:0]});
      mHi = exp[63:32];
      mLo = exp[31:0];
    end
  endtask

  initial begin
    int cycles;
    #12 reset = 1'b0;
    step();
    MDVop = OP_MFHI;
    #1;
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_stall", {63'd0, stall}, 64'd0);
    checkOutput("rst_HI", {32'd0, HI}, 64'd0);
    checkOutput("rst_LO", {32'd0, LO}, 64'd0);
    checkOutput("rst_ans", {32'd0, MDV_ans}, 64'd0);

    issueOp(OP_MULT, 32'hFFFFFFFE, 32'd3);
    waitDone("mult", 0, 5);
    checkOutput("mult_HIconst", {32'd0, HI}, 64'h0000_0000_FFFF_FFFF);
    issueOp(OP_MULTU, 32'hFFFFFFFE, 32'd3);
    waitDone("multu", 0, 5);
    checkOutput("multu_HIconst", {32'd0, HI}, 64'h0000_0000_0000_0002);
    issueOp(OP_DIV, 32'hFFFFFFF9, 32'd2);
    waitDone("div", 0, 10);
    checkOutput("div_LOconst", {32'd0, LO}, 64'h0000_0000_FFFF_FFFD);
    issueOp(OP_DIVU, 32'd7, 32'd2);
    waitDone("divu", 0, 10);

    applyStimulus(1'b0, OP_MTHI, 32'h12345678, 32'd0, 1'b0);
    mHi = 32'h12345678;
    MDVop = OP_MFHI;
    #1;
    checkOutput("mfhi_ans", {32'd0, MDV_ans}, {32'd0, mHi});
    applyStimulus(1'b0, OP_MTLO, 32'h0000DEAD, 32'd0, 1'b1);
    MDVop = OP_MFLO;
    #1;
    checkOutput("mtloReq_ans", {32'd0, MDV_ans}, {32'd0, mLo});
    MDVop = OP_MTHI;
    #1;
    checkOutput("otherOp_ans", {32'd0, MDV_ans}, 64'd0);

    applyStimulus(1'b0, OP_MTHI, 32'hAAAA0000, 32'd0, 1'b0);
    applyStimulus(1'b0, OP_MTLO, 32'h00005555, 32'd0, 1'b0);
    mHi = 32'hAAAA0000;
    mLo = 32'h00005555;
    issueOp(OP_DIV, 32'd100, 32'd0);
    waitDone("div0", 0, 10);
    issueOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitDone("divOvf", 0, 10);

    start = 1'b1; MDVop = OP_MULT; A = 32'd9; B = 32'd9; Req = 1'b1;
    #1;
    checkOutput("reqStart_stall", {63'd0, stall}, 64'd1);
    applyStimulus(1'b1, OP_MULT, 32'd9, 32'd9, 1'b1);
    checkOutput("reqStart_busy", {63'd0, busy}, 64'd0);
    applyStimulus(1'b1, OP_MFHI, 32'd9, 32'd9, 1'b0);
    checkOutput("badOp_busy", {63'd0, busy}, 64'd0);
    checkOutput("ignored_HI", {32'd0, HI}, {32'd0, mHi});
    checkOutput("ignored_LO", {32'd0, LO}, {32'd0, mLo});

    issueOp(OP_MULT, 32'h00010000, 32'h00010000);
    step();
    $display("[TB] note: issuing start while busy (hazard protocol violation, must be ignored)");
    applyStimulus(1'b1, OP_MULT, 32'd5, 32'd5, 1'b0);
    applyStimulus(1'b0, OP_MTLO, 32'hBEEF0000, 32'd0, 1'b0);
    MDVop = OP_MFHI;
    #1;
    checkOutput("inflight_ans", {32'd0, MDV_ans}, {32'd0, mHi});
    MDVop = OP_MFLO;
    waitDone("busyIgnore", 3, 5);
    step();
    checkOutput("busyIgnore_idle", {63'd0, busy}, 64'd0);

    issueOp(OP_MULT, 32'd1234, 32'd5678);
    step();
    step();
    #2 reset = 1'b1;
    #1;
    checkOutput("midRst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midRst_HI", {32'd0, HI}, 64'd0);
    checkOutput("midRst_LO", {32'd0, LO}, 64'd0);
    scoreboard.delete();
    mHi = '0;
    mLo = '0;
    #1 reset = 1'b0;
    cycles = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (busy === 1'b1) cycles++;
    end
    checkOutput("postRst_busyCycles", 64'(cycles), 64'd0);
    checkOutput("postRst_HI", {32'd0, HI}, 64'd0);
    checkOutput("postRst_LO", {32'd0, LO}, 64'd0);
    checkOutput("sb_drained", 64'(scoreboard.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
